// File: rtl/mmio_initiator_pkg.sv
// Shared types and widths for the MMIO request initiator.
// Latency and backpressure: not applicable (declarations only).
package mmio_initiator_pkg;

    localparam int MMIO_ADDR_W = 16;
    localparam int MMIO_TID_W  = 9;
    localparam int MMIO_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } t_mmio_init_state;

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Read-response watchdog: counts enabled cycles after a clear, flags TIMEOUT_CYCLES-1.
// Latency: tc is combinational from the count register; no backpressure.
module mmio_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mmio_initiator.sv
// Host-side MMIO initiator: one command in flight, strobe the cycle after acceptance.
// Latency: write result 2 cycles after accept; reads wait for a TID match or timeout; result held until res_ready.
module mmio_initiator
    import mmio_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 512,
    parameter int ERR_CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [MMIO_ADDR_W-1:0] cmd_addr,
    input  logic [MMIO_DATA_W-1:0] cmd_wdata,
    output logic                   mmio_wr_valid,
    output logic                   mmio_rd_valid,
    output logic [MMIO_ADDR_W-1:0] mmio_addr,
    output logic [MMIO_TID_W-1:0]  mmio_tid,
    output logic [MMIO_DATA_W-1:0] mmio_data,
    input  logic                   rsp_valid,
    input  logic [MMIO_TID_W-1:0]  rsp_tid,
    input  logic [MMIO_DATA_W-1:0] rsp_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_write,
    output logic [MMIO_DATA_W-1:0] res_rdata,
    output logic                   res_timeout,
    output logic [ERR_CNT_W-1:0]   stale_cnt
);

    t_mmio_init_state state, state_nxt;

    logic                   cmd_write_q;
    logic [MMIO_TID_W-1:0]  tid;
    logic                   tc, accept, rsp_match, tid_adv, stale_hit;

    logic                   cmd_ready_d, wr_valid_d, rd_valid_d;
    logic [MMIO_ADDR_W-1:0] addr_d;
    logic [MMIO_TID_W-1:0]  tid_d;
    logic [MMIO_DATA_W-1:0] data_d, res_rdata_d;
    logic                   res_valid_d, res_write_d, res_timeout_d;

    assign accept    = (state == IDLE) && cmd_valid;
    assign rsp_match = (state == WAIT_RSP) && rsp_valid && (rsp_tid == tid);
    assign tid_adv   = (state == WAIT_RSP) && (rsp_match || tc);
    assign stale_hit = rsp_valid && !rsp_match;

    mmio_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk(clk),
        .rst(rst),
        .clr(state == ISSUE),
        .en (state == WAIT_RSP),
        .tc (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cmd_valid) state_nxt = ISSUE;
            ISSUE:    state_nxt = cmd_write_q ? DONE : WAIT_RSP;
            WAIT_RSP: if (rsp_match || tc) state_nxt = DONE;
            DONE:     if (res_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Strobe fields are driven straight from the command at acceptance so the
    // request lands in the cycle right after the handshake; zero otherwise.
    always_comb begin
        cmd_ready_d   = (state_nxt == IDLE);
        wr_valid_d    = accept && cmd_write;
        rd_valid_d    = accept && !cmd_write;
        addr_d        = accept ? cmd_addr : '0;
        tid_d         = rd_valid_d ? tid : '0;
        data_d        = wr_valid_d ? cmd_wdata : '0;
        res_valid_d   = (state_nxt == DONE);
        res_write_d   = res_write;
        res_rdata_d   = res_rdata;
        res_timeout_d = res_timeout;
        case (state)
            ISSUE: begin
                if (cmd_write_q) begin
                    res_write_d   = 1'b1;
                    res_rdata_d   = '0;
                    res_timeout_d = 1'b0;
                end
            end
            WAIT_RSP: begin
                if (rsp_match) begin
                    res_write_d   = 1'b0;
                    res_rdata_d   = rsp_data;
                    res_timeout_d = 1'b0;
                end else if (tc) begin
                    res_write_d   = 1'b0;
                    res_rdata_d   = '0;
                    res_timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_write_d   = 1'b0;
                    res_rdata_d   = '0;
                    res_timeout_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready     <= 1'b1;
            mmio_wr_valid <= 1'b0;
            mmio_rd_valid <= 1'b0;
            mmio_addr     <= '0;
            mmio_tid      <= '0;
            mmio_data     <= '0;
            res_valid     <= 1'b0;
            res_write     <= 1'b0;
            res_rdata     <= '0;
            res_timeout   <= 1'b0;
        end else begin
            cmd_ready     <= cmd_ready_d;
            mmio_wr_valid <= wr_valid_d;
            mmio_rd_valid <= rd_valid_d;
            mmio_addr     <= addr_d;
            mmio_tid      <= tid_d;
            mmio_data     <= data_d;
            res_valid     <= res_valid_d;
            res_write     <= res_write_d;
            res_rdata     <= res_rdata_d;
            res_timeout   <= res_timeout_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_write_q <= 1'b0;
            tid         <= '0;
            stale_cnt   <= '0;
        end else begin
            if (accept) cmd_write_q <= cmd_write;
            if (tid_adv) tid <= tid + MMIO_TID_W'(1);
            if (stale_hit && (stale_cnt != '1)) stale_cnt <= stale_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: doc/mmio_initiator.md
# mmio_initiator

Synthesizable CCI-P MMIO request initiator: accepts single read/write commands from on-chip logic, drives them as MMIO requests (mmioWrValid/mmioRdValid with header address, TID and data) toward an MMIO responder AFU, and returns read data or a timeout. It sits on the host side of the MMIO channel, in place of the host CPU. It is used for on-FPGA self-test of user registers and for standalone loopback of the AFU register map without a host.

## Interface
Parameters:
- TIMEOUT_CYCLES, 512, cycles to wait in WAIT_RSP for a matching read response before giving up (≥2).
- ERR_CNT_W, 16, width of the saturating stale-response counter.

Ports:
- clk  input  1  single clock; every register samples on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high only in IDLE.
- cmd_write  input  1  1 = MMIO write, 0 = MMIO read.
- cmd_addr  input  16  MMIO address (CCI-P DW index, e.g. 16'h0020).
- cmd_wdata  input  64  write data.
- mmio_wr_valid  output  1  one-cycle write request strobe.
- mmio_rd_valid  output  1  one-cycle read request strobe.
- mmio_addr  output  16  request address.
- mmio_tid  output  9  request TID.
- mmio_data  output  64  write data; 0 on reads.
- rsp_valid  input  1  read response valid (responder tx.c2.mmioRdValid).
- rsp_tid  input  9  response TID.
- rsp_data  input  64  response data.
- res_valid  output  1  result available; held until res_ready.
- res_ready  input  1  result consumed.
- res_write  output  1  result belongs to a write.
- res_rdata  output  64  read data; 0 for writes and timeouts.
- res_timeout  output  1  read timed out.
- stale_cnt  output  ERR_CNT_W  count of ignored responses, saturating at all-ones.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_write, cmd_addr and cmd_wdata, then go to ISSUE.
- ISSUE, one cycle:
  - Write: assert mmio_wr_valid with mmio_addr and mmio_data, then go to DONE with res_write=1.
  - Read: assert mmio_rd_valid with mmio_addr and mmio_tid = current TID, then go to WAIT_RSP and clear the timeout counter.
- WAIT_RSP:
  - rsp_valid with rsp_tid == issued TID: latch rsp_data into res_rdata, res_timeout=0, go to DONE, and increment TID (9-bit wrap, 511 -> 0).
  - rsp_valid with a mismatched TID: ignored; stale_cnt increments.
  - Counter reaches TIMEOUT_CYCLES-1 with no match: res_timeout=1, res_rdata=0, TID increments, go to DONE.
- DONE: res_valid=1. On res_ready, go to IDLE.
- rsp_valid in any state other than WAIT_RSP increments stale_cnt. This covers late responses after a timeout.
- A match and the final timeout cycle occurring together: the match wins.
- A write never expects a response and never changes the TID.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, TID 0, stale_cnt 0, state IDLE. Except cmd_ready, which is 1, because state is IDLE after reset.
- Reset asserted mid-operation aborts the transaction immediately: no strobe and no result are produced.
- Command accepted at edge N: request strobe high during cycle N+1, exactly one cycle.
- Write: res_valid high from cycle N+2.
- Read with a 1-cycle responder (response sampled at edge N+2): res_valid high from cycle N+3.
- Timeout: res_valid high exactly TIMEOUT_CYCLES+1 cycles after the strobe cycle.
- res_valid and res_ready both high at an edge: cmd_ready=1 in the next cycle. Back-to-back throughput is one write per 3 cycles.
- cmd_ready is low in ISSUE, WAIT_RSP and DONE. A cmd_valid in those states is not accepted.

## Structure
- Package mmio_initiator_pkg holds:
  - the state enum t_mmio_init_state;
  - the constants MMIO_ADDR_W=16, MMIO_TID_W=9, MMIO_DATA_W=64.
- One sub-module, mmio_timeout_ctr: clear/enable inputs, terminal-count output, parameterized by TIMEOUT_CYCLES.
- TID register and stale counter live in the top level.

## Test plan
- Write 64'hDEADBEEF_0000_1234 to 16'h0020 -> mmio_wr_valid for one cycle with mmio_addr=16'h0020 and that data; res_valid with res_write=1 two cycles after acceptance.
- Read 16'h0020 against a 1-cycle responder returning 64'hCAFE with matching TID 0 -> res_rdata=64'hCAFE, res_timeout=0; the next read carries TID 1.
- Read with the responder silent, TIMEOUT_CYCLES=8 -> res_timeout=1 and res_rdata=0 exactly 9 cycles after the strobe. A response with the old TID arriving later -> stale_cnt=1, no result.
- Response with TID 5 while waiting on TID 3, then TID 3 -> stale_cnt=1, and the TID 3 data is returned.
- 512 consecutive reads -> TID wraps 511 -> 0. Holding res_ready low for 10 cycles keeps res_valid and the data stable.
- Assert rst during WAIT_RSP -> all outputs 0 except cmd_ready=1, TID=0. A subsequent response counts as stale.
